// File: rtl/sk6812_frame_sequencer_if.sv
// Pixel-store read port between the SK6812 frame sequencer (master) and the pixel memory (slave).
// Handshake: PixRdo is a one-cycle read strobe with PixAddro; PixDatai is valid exactly one cycle later, with no backpressure.
interface sk6812_frame_sequencer_if #(
    parameter int AW = 3
);
    logic          PixRdo;
    logic [AW-1:0] PixAddro;
    logic [31:0]   PixDatai;

    modport master (output PixRdo, output PixAddro, input PixDatai);
    modport slave  (input PixRdo, input PixAddro, output PixDatai);
endinterface

// File: rtl/sk6812_frame_sequencer.sv
// Streams NUM_LEDS pixel words from a 1-cycle-latency store onto the SK6812 data line,
// then holds the line low for the latch time; back-to-back requests collapse into one pending frame.
module sk6812_frame_sequencer #(
    parameter int NUM_LEDS = 8,
    parameter int BPP      = 24,
    parameter int BIT_CYC  = 60,
    parameter int T0H_CYC  = 14,
    parameter int T1H_CYC  = 29,
    parameter int RST_CYC  = 4000,
    parameter int AW       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                            SYSCLK1,
    input  logic                            PllLocked,
    input  logic                            Starti,
    sk6812_frame_sequencer_if.master        pix,
    output logic                            SK6812o,
    output logic                            Busyo,
    output logic                            FrameDoneo,
    output logic [2:0]                      state_dbg
);

    localparam int CW = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam int RW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    localparam logic [CW-1:0] CYC_TOP  = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] T0H_LEN  = CW'(T0H_CYC);
    localparam logic [CW-1:0] T1H_LEN  = CW'(T1H_CYC);
    localparam logic [RW-1:0] LAT_TOP  = RW'(RST_CYC - 1);
    localparam logic [5:0]    BIT_TOP  = 6'(BPP - 1);
    localparam logic [AW-1:0] LAST_LED = AW'(NUM_LEDS - 1);

    // The prefetched word lands two clocks after the last bit starts, so a bit must outlast that.
    if ((BPP != 24 && BPP != 32) || NUM_LEDS < 1 || BIT_CYC < 4 ||
        T0H_CYC >= T1H_CYC || T1H_CYC >= BIT_CYC || RST_CYC < 1) begin : g_bad_params
        $error("sk6812_frame_sequencer: illegal parameter set");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        SEND  = 3'd3,
        LATCH = 3'd4
    } state_t;

    state_t        state;
    logic          pending;
    logic          rd_q;
    logic [31:0]   shift;
    logic [31:0]   hold;
    logic [5:0]    bit_cnt;
    logic [CW-1:0] cyc_cnt;
    logic [AW-1:0] led_cnt;
    logic [RW-1:0] lat_cnt;
    logic [CW-1:0] hi_len;

    assign hi_len    = shift[BPP-1] ? T1H_LEN : T0H_LEN;
    assign state_dbg = state;

    always_ff @(posedge SYSCLK1 or negedge PllLocked) begin
        if (!PllLocked) begin
            state        <= IDLE;
            pending      <= 1'b0;
            rd_q         <= 1'b0;
            shift        <= '0;
            hold         <= '0;
            bit_cnt      <= '0;
            cyc_cnt      <= '0;
            led_cnt      <= '0;
            lat_cnt      <= '0;
            SK6812o      <= 1'b0;
            Busyo        <= 1'b0;
            FrameDoneo   <= 1'b0;
            pix.PixRdo   <= 1'b0;
            pix.PixAddro <= '0;
        end else begin
            pix.PixRdo <= 1'b0;
            FrameDoneo <= 1'b0;
            rd_q       <= pix.PixRdo;
            if (rd_q) begin
                hold <= pix.PixDatai;
            end
            if (Starti && state != IDLE) begin
                pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (Starti) begin
                        state        <= FETCH;
                        Busyo        <= 1'b1;
                        pix.PixRdo   <= 1'b1;
                        pix.PixAddro <= '0;
                    end
                end

                FETCH: begin
                    state <= LOAD;
                end

                LOAD: begin
                    shift   <= pix.PixDatai;
                    bit_cnt <= BIT_TOP;
                    led_cnt <= '0;
                    cyc_cnt <= '0;
                    state   <= SEND;
                end

                SEND: begin
                    SK6812o <= (cyc_cnt < hi_len);
                    // Fetch the next LED's word while its predecessor's last bit is on the wire.
                    if (bit_cnt == 6'd0 && cyc_cnt == '0 && led_cnt != LAST_LED) begin
                        pix.PixRdo   <= 1'b1;
                        pix.PixAddro <= led_cnt + AW'(1);
                    end
                    if (cyc_cnt == CYC_TOP) begin
                        cyc_cnt <= '0;
                        if (bit_cnt == 6'd0) begin
                            if (led_cnt == LAST_LED) begin
                                lat_cnt <= '0;
                                state   <= LATCH;
                            end else begin
                                shift   <= hold;
                                led_cnt <= led_cnt + AW'(1);
                                bit_cnt <= BIT_TOP;
                            end
                        end else begin
                            shift   <= shift << 1;
                            bit_cnt <= bit_cnt - 6'd1;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + CW'(1);
                    end
                end

                LATCH: begin
                    SK6812o <= 1'b0;
                    if (lat_cnt == LAT_TOP) begin
                        FrameDoneo <= 1'b1;
                        // A request landing on the final latch clock still chains the next frame.
                        if (pending || Starti) begin
                            pending      <= 1'b0;
                            state        <= FETCH;
                            pix.PixRdo   <= 1'b1;
                            pix.PixAddro <= '0;
                        end else begin
                            Busyo <= 1'b0;
                            state <= IDLE;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + RW'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sk6812_frame_sequencer.sv
// Directed bench for the SK6812 frame sequencer: a 2-LED GRB instance and a 1-LED GRBW instance,
// with scoreboard queues of expected pulse widths, rise times, reads and frame-done times.
module tb_sk6812_frame_sequencer;
  localparam int BIT_CYC = 10;
  localparam int T0H     = 3;
  localparam int T1H     = 6;
  localparam int RST_CYC = 20;
  localparam int FRAME24 = 2 + 2 * 24 * BIT_CYC + RST_CYC;
  localparam int FRAME32 = 2 + 1 * 32 * BIT_CYC + RST_CYC;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start24 = 1'b0;
  logic start32 = 1'b0;
  logic sk24, busy24, done24, sk32, busy32, done32;
  logic [2:0] st24, st32;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  logic mon_en = 1'b0;

  logic [31:0] mem24 [2];
  logic [31:0] mem32;

  logic [31:0] exp_q[$];
  logic [31:0] exp_first_q[$];
  logic [31:0] exp_done_q[$];
  logic [32:0] exp_rd_q[$];
  logic [31:0] exp32_q[$];
  logic [31:0] exp32_done_q[$];

  int prev24 = 0, rise24 = 0, last_rise24 = 0, bit_idx24 = 0;
  int prev32 = 0, rise32 = 0;
  int busy_from = -1, busy_to = -1, busy_low = 0;
  int idle_from = -1, idle_to = -1, idle_act = 0;

  sk6812_frame_sequencer_if #(.AW(1)) pix24 ();
  sk6812_frame_sequencer_if #(.AW(1)) pix32 ();

  sk6812_frame_sequencer #(
    .NUM_LEDS(2), .BPP(24), .BIT_CYC(BIT_CYC), .T0H_CYC(T0H), .T1H_CYC(T1H), .RST_CYC(RST_CYC)
  ) dut24 (
    .SYSCLK1(clk), .PllLocked(rst_n), .Starti(start24), .pix(pix24),
    .SK6812o(sk24), .Busyo(busy24), .FrameDoneo(done24), .state_dbg(st24)
  );

  sk6812_frame_sequencer #(
    .NUM_LEDS(1), .BPP(32), .BIT_CYC(BIT_CYC), .T0H_CYC(T0H), .T1H_CYC(T1H), .RST_CYC(RST_CYC)
  ) dut32 (
    .SYSCLK1(clk), .PllLocked(rst_n), .Starti(start32), .pix(pix32),
    .SK6812o(sk32), .Busyo(busy32), .FrameDoneo(done32), .state_dbg(st32)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // pixel store with one-cycle read latency
  always @(posedge clk) begin
    if (pix24.PixRdo) pix24.PixDatai <= mem24[pix24.PixAddro];
    if (pix32.PixRdo) pix32.PixDatai <= mem32;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic push_frame24(input int t0);
    for (int led = 0; led < 2; led++)
      for (int b = 23; b >= 0; b--)
        exp_q.push_back(mem24[led][b] ? T1H : T0H);
    exp_first_q.push_back(t0 + 3);
    exp_done_q.push_back(t0 + FRAME24);
    exp_rd_q.push_back({1'b0, 32'(t0)});
    exp_rd_q.push_back({1'b1, 32'(t0 + 3 + 23 * BIT_CYC)});
  endtask

  task automatic do_start24(input int nf, output int t0);
    @(negedge clk);
    t0 = cyc + 1;
    for (int k = 0; k < nf; k++) push_frame24(t0 + k * FRAME24);
    start24 = 1'b1;
    @(negedge clk);
    start24 = 1'b0;
  endtask

  task automatic do_start32(output int t0);
    @(negedge clk);
    t0 = cyc + 1;
    for (int b = 31; b >= 0; b--) exp32_q.push_back(mem32[b] ? T1H : T0H);
    exp32_done_q.push_back(t0 + FRAME32);
    start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
  endtask

  task automatic pulse_start24();
    @(negedge clk);
    start24 = 1'b1;
    @(negedge clk);
    start24 = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_widths_left"}, exp_q.size(), 0);
    check({tag, "_rises_left"}, exp_first_q.size(), 0);
    check({tag, "_dones_left"}, exp_done_q.size(), 0);
    check({tag, "_reads_left"}, exp_rd_q.size(), 0);
  endtask

  // scoreboard / monitor for the GRB instance
  always @(negedge clk) begin
    logic [31:0] e;
    logic [32:0] r;
    if (!mon_en) begin
      prev24 = sk24;
      bit_idx24 = 0;
    end else begin
      if (sk24 && prev24 == 0) begin
        if (bit_idx24 == 0) begin
          check("first_rise_expected", exp_first_q.size() != 0, 1);
          if (exp_first_q.size() != 0) begin
            e = exp_first_q.pop_front();
            check("first_rise_cyc", cyc, e);
          end
        end else begin
          check("bit_period", cyc - last_rise24, BIT_CYC);
        end
        last_rise24 = cyc;
        rise24 = cyc;
        bit_idx24++;
      end
      if (!sk24 && prev24 == 1) begin
        check("pulse_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("high_width", cyc - rise24, e);
        end
      end
      if (done24) begin
        check("done_expected", exp_done_q.size() != 0, 1);
        if (exp_done_q.size() != 0) begin
          e = exp_done_q.pop_front();
          check("done_cyc", cyc, e);
        end
        bit_idx24 = 0;
      end
      if (pix24.PixRdo) begin
        check("read_expected", exp_rd_q.size() != 0, 1);
        if (exp_rd_q.size() != 0) begin
          r = exp_rd_q.pop_front();
          check("read_addr", pix24.PixAddro, r[32]);
          check("read_cyc", cyc, r[31:0]);
        end
      end
      prev24 = sk24;
    end
    if (cyc >= busy_from && cyc <= busy_to && !busy24) busy_low++;
    if (cyc >= idle_from && cyc <= idle_to &&
        (sk24 || pix24.PixRdo || busy24 || done24 || sk32 || pix32.PixRdo || busy32 || done32))
      idle_act++;
  end

  // scoreboard / monitor for the GRBW instance
  always @(negedge clk) begin
    logic [31:0] e;
    if (mon_en) begin
      if (sk32 && prev32 == 0) rise32 = cyc;
      if (!sk32 && prev32 == 1) begin
        check("pulse32_expected", exp32_q.size() != 0, 1);
        if (exp32_q.size() != 0) begin
          e = exp32_q.pop_front();
          check("high_width32", cyc - rise32, e);
        end
      end
      if (done32) begin
        check("done32_expected", exp32_done_q.size() != 0, 1);
        if (exp32_done_q.size() != 0) begin
          e = exp32_done_q.pop_front();
          check("done32_cyc", cyc, e);
        end
      end
    end
    prev32 = sk32;
  end

  initial begin
    int t0;
    mem24[0] = 32'h5A80_0001;
    mem24[1] = 32'hC300_00FF;
    mem32    = 32'hA5A5_A5A5;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_sk", sk24, 0);
    check("rst_busy", busy24, 0);
    check("rst_done", done24, 0);
    check("rst_rd", pix24.PixRdo, 0);
    check("rst_addr", pix24.PixAddro, 0);
    check("rst_state", st24, 0);
    check("rst_sk32", sk32, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // single GRB frame: widths, continuity, reads, latch and total length
    do_start24(1, t0);
    check("busy_after_start", busy24, 1);
    wait_until(t0 + FRAME24 + 5);
    check_drained("frame1");
    check("busy_after_frame", busy24, 0);

    // GRBW frame, MSB of the 32-bit word first
    do_start32(t0);
    wait_until(t0 + FRAME32 + 5);
    check("grbw_widths_left", exp32_q.size(), 0);
    check("grbw_dones_left", exp32_done_q.size(), 0);
    check("grbw_busy_after", busy32, 0);

    // back-to-back: two collapsed requests in frame 1, one on frame 2's latch-end clock
    do_start24(3, t0);
    busy_from = t0;
    busy_to = t0 + 3 * FRAME24 - 1;
    wait_until(t0 + 100);
    pulse_start24();
    wait_until(t0 + 200);
    pulse_start24();
    wait_until(t0 + 2 * FRAME24 - 1);
    start24 = 1'b1;
    @(negedge clk);
    start24 = 1'b0;
    wait_until(t0 + 3 * FRAME24);
    check("b2b_busy_falls", busy24, 0);
    wait_until(t0 + 3 * FRAME24 + 30);
    check("b2b_busy_gaps", busy_low, 0);
    check_drained("b2b");

    // reset mid-LED1 while the line is high, with a request pending
    do_start24(1, t0);
    wait_until(t0 + 50);
    pulse_start24();
    wait_until(t0 + 3 + 24 * BIT_CYC + 1);
    check("sk_before_reset", sk24, 1);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_sk", sk24, 0);
    check("async_rst_busy", busy24, 0);
    check("async_rst_rd", pix24.PixRdo, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    exp_q.delete();
    exp_first_q.delete();
    exp_done_q.delete();
    exp_rd_q.delete();
    mon_en = 1'b1;
    repeat (700) @(negedge clk);
    check("pending_cleared_busy", busy24, 0);
    check("pending_cleared_state", st24, 0);
    do_start24(1, t0);
    wait_until(t0 + FRAME24 + 5);
    check_drained("post_reset");

    // idle: nothing moves without a request
    idle_from = cyc + 1;
    idle_to = cyc + 1000;
    wait_until(idle_to + 1);
    check("idle_activity", idle_act, 0);

    check_drained("final");
    check("final_grbw_left", exp32_q.size() + exp32_done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
